// File: rtl/if_fetch_stage_if.sv
// Instruction-cache fetch bus between the fetch stage (master) and the icache (slave).
// Handshake: the master holds ic_req/ic_addr; a word is taken only in a cycle where ic_req & ic_ready.
interface if_fetch_stage_if;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_ready;
   logic [31:0] ic_rdata;

   modport master (output ic_req, output ic_addr, input ic_ready, input ic_rdata);
   modport slave  (input ic_req, input ic_addr, output ic_ready, output ic_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, requests words from the icache, predecodes beq for the
// always-taken predictor and loads the IF/ID register; keeps saturating perf counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   if_fetch_stage_if.master     ic,
   input  logic [31:0]          pc_next,
   input  logic                 correct,
   input  logic                 hazard_stall,
   output logic                 branch_if,
   output logic [31:0]          pc_add_4,
   output logic [31:0]          pc_add_imm,
   output logic                 stall,
   output logic                 if_id_valid,
   output logic [31:0]          if_id_instr,
   output logic [31:0]          if_id_pc,
   output logic [CNT_W-1:0]     fetch_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [1:0]           fsm_state
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      MISS  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   logic [31:0] instr;
   logic [31:0] imm_b;
   logic        is_beq;
   logic        req;

   assign instr     = ic.ic_rdata;
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      case (state)
         BOOT:    state_nxt = FETCH;
         FETCH: begin
            req = 1'b1;
            if (!ic.ic_ready) state_nxt = MISS;
         end
         MISS: begin
            req = 1'b1;
            if (ic.ic_ready) state_nxt = FETCH;
         end
         default: state_nxt = BOOT;
      endcase
   end

   assign ic.ic_req  = req;
   assign ic.ic_addr = pc_q;

   // A word returned while hazard_stall is high is dropped; the PC holds so it is re-fetched.
   assign stall = (state == BOOT) | (req & ~ic.ic_ready) | hazard_stall;

   assign is_beq     = (instr[6:0] == 7'b1100011) && (instr[14:12] == 3'b000);
   assign imm_b      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign pc_add_4   = pc_q + 32'd4;
   assign pc_add_imm = pc_q + imm_b;
   // Gated by correct so a wrong-path beq cannot override the predictor's redirect.
   assign branch_if  = is_beq & req & ic.ic_ready & correct;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_instr <= 32'h0000_0013;
         if_id_pc    <= 32'h0000_0000;
         fetch_cnt   <= '0;
         flush_cnt   <= '0;
         stall_cnt   <= '0;
      end else if (!stall) begin
         pc_q <= pc_next;
         if (!correct) begin
            if_id_valid <= 1'b0;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
         end else begin
            if_id_valid <= 1'b1;
            if_id_instr <= instr;
            if_id_pc    <= pc_q;
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
         end
      end else if (state != BOOT) begin
         if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: IF/ID loads are scoreboarded through exp_q,
// combinational fetch-cycle outputs and counters are checked inline.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_next;
   logic        correct;
   logic        hazard_stall;

   logic        branch_if, stall, if_id_valid;
   logic [31:0] pc_add_4, pc_add_imm, if_id_instr, if_id_pc;
   logic [15:0] fetch_cnt, flush_cnt, stall_cnt;
   logic [1:0]  fsm_state;

   logic        branch_if2, stall2, if_id_valid2;
   logic [31:0] pc_add_42, pc_add_imm2, if_id_instr2, if_id_pc2;
   logic [1:0]  fetch_cnt2, flush_cnt2, stall_cnt2;
   logic [1:0]  fsm_state2;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q[$];

   if_fetch_stage_if u_ic ();
   if_fetch_stage_if u_ic2 ();
   assign u_ic2.ic_ready = u_ic.ic_ready;
   assign u_ic2.ic_rdata = u_ic.ic_rdata;

   if_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .ic(u_ic.master), .pc_next(pc_next), .correct(correct),
      .hazard_stall(hazard_stall), .branch_if(branch_if), .pc_add_4(pc_add_4),
      .pc_add_imm(pc_add_imm), .stall(stall), .if_id_valid(if_id_valid),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .fetch_cnt(fetch_cnt),
      .flush_cnt(flush_cnt), .stall_cnt(stall_cnt), .fsm_state(fsm_state)
   );

   // Narrow-counter copy fed the same stimulus, used for saturation.
   if_fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .ic(u_ic2.master), .pc_next(pc_next), .correct(correct),
      .hazard_stall(hazard_stall), .branch_if(branch_if2), .pc_add_4(pc_add_42),
      .pc_add_imm(pc_add_imm2), .stall(stall2), .if_id_valid(if_id_valid2),
      .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2), .fetch_cnt(fetch_cnt2),
      .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2), .fsm_state(fsm_state2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic rdy, input logic [31:0] rdata, input logic [31:0] nxt,
                         input logic cor, input logic haz);
      u_ic.ic_ready = rdy;
      u_ic.ic_rdata = rdata;
      pc_next       = nxt;
      correct       = cor;
      hazard_stall  = haz;
   endtask

   function automatic logic [31:0] alu_word(input logic [31:0] pc);
      return {pc[11:0], 20'h00013};
   endfunction

   task automatic hit(input logic [31:0] pc, input logic [31:0] word, input logic [31:0] nxt,
                      input logic exp_br);
      set_in(1'b1, word, nxt, 1'b1, 1'b0);
      #1;
      check("hit_addr", {32'h0, u_ic.ic_addr}, {32'h0, pc});
      check("hit_req", {63'h0, u_ic.ic_req}, 64'd1);
      check("hit_stall", {63'h0, stall}, 64'd0);
      check("hit_branch_if", {63'h0, branch_if}, {63'h0, exp_br});
      check("hit_pc_add_4", {32'h0, pc_add_4}, {32'h0, pc + 32'd4});
      exp_q.push_back({pc, word});
      @(negedge clk);
   endtask

   task automatic miss(input logic [31:0] pc, input logic haz, input logic [31:0] held_pc);
      set_in(1'b0, 32'hDEAD_BEEF, 32'h0BAD_0000, 1'b1, haz);
      #1;
      check("miss_addr", {32'h0, u_ic.ic_addr}, {32'h0, pc});
      check("miss_stall", {63'h0, stall}, 64'd1);
      check("miss_if_id_pc", {32'h0, if_id_pc}, {32'h0, held_pc});
      @(negedge clk);
   endtask

   task automatic hazard(input logic [31:0] pc, input logic [31:0] held_pc);
      set_in(1'b1, 32'h1234_5013, 32'h0BAD_0000, 1'b1, 1'b1);
      #1;
      check("haz_addr", {32'h0, u_ic.ic_addr}, {32'h0, pc});
      check("haz_stall", {63'h0, stall}, 64'd1);
      check("haz_if_id_pc", {32'h0, if_id_pc}, {32'h0, held_pc});
      @(negedge clk);
   endtask

   // Monitor: each new IF/ID load (fetch_cnt step) must match the oldest expected entry.
   logic [15:0] last_fetch = '0;
   always @(negedge clk) begin
      if (!rst && fetch_cnt != last_fetch && fetch_cnt != 16'd0) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_load", {if_id_pc, if_id_instr}, 64'h0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_if_id", {if_id_pc, if_id_instr}, e);
            check("sb_valid", {63'h0, if_id_valid}, 64'd1);
         end
      end
      last_fetch = fetch_cnt;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: time limit reached, expected end of sequence");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      rst = 1'b1;
      set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check("rst_valid", {63'h0, if_id_valid}, 64'd0);
      check("rst_instr", {32'h0, if_id_instr}, 64'h13);
      check("rst_pc", {32'h0, if_id_pc}, 64'h0);
      check("rst_req", {63'h0, u_ic.ic_req}, 64'd0);
      check("rst_stall", {63'h0, stall}, 64'd1);
      check("rst_cnts", {16'h0, fetch_cnt, flush_cnt, stall_cnt}, 64'h0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("boot_req", {63'h0, u_ic.ic_req}, 64'd0);
      check("boot_addr", {32'h0, u_ic.ic_addr}, 64'h0);
      check("boot_stall", {63'h0, stall}, 64'd1);
      @(negedge clk);

      hit(32'h00, alu_word(32'h00), 32'h04, 1'b0);
      hit(32'h04, alu_word(32'h04), 32'h08, 1'b0);
      hit(32'h08, alu_word(32'h08), 32'h0C, 1'b0);
      hit(32'h0C, alu_word(32'h0C), 32'h08, 1'b0);
      check("fetch_cnt_4", {48'h0, fetch_cnt}, 64'd4);
      check("stall_cnt_0", {48'h0, stall_cnt}, 64'd0);

      // Miss at 8 for three cycles, then the word arrives.
      miss(32'h08, 1'b0, 32'h0C);
      miss(32'h08, 1'b0, 32'h0C);
      miss(32'h08, 1'b0, 32'h0C);
      hit(32'h08, alu_word(32'h08), 32'h20, 1'b0);
      check("stall_cnt_3", {48'h0, stall_cnt}, 64'd3);

      // beq x0,x0,+16 at 0x20.
      set_in(1'b1, 32'h0000_0863, 32'h30, 1'b1, 1'b0);
      #1;
      check("beq16_imm", {32'h0, pc_add_imm}, 64'h30);
      check("beq16_add4", {32'h0, pc_add_4}, 64'h24);
      check("beq16_br", {63'h0, branch_if}, 64'd1);
      exp_q.push_back({32'h20, 32'h0000_0863});
      @(negedge clk);
      hit(32'h30, alu_word(32'h30), 32'h04, 1'b0);

      // beq imm=-8 at 0x4 on the wrong path: flushed, redirect to 0x24.
      set_in(1'b1, 32'hFE00_0CE3, 32'h24, 1'b0, 1'b0);
      #1;
      check("beqm8_imm", {32'h0, pc_add_imm}, 64'hFFFF_FFFC);
      check("flush_br", {63'h0, branch_if}, 64'd0);
      check("flush_stall", {63'h0, stall}, 64'd0);
      @(negedge clk);
      check("flush_valid", {63'h0, if_id_valid}, 64'd0);
      check("flush_cnt_1", {48'h0, flush_cnt}, 64'd1);
      check("flush_next_addr", {32'h0, u_ic.ic_addr}, 64'h24);
      check("flush_hold_pc", {32'h0, if_id_pc}, 64'h30);
      hit(32'h24, alu_word(32'h24), 32'h28, 1'b0);

      // Load-use stall for two cycles, then hazard together with a miss.
      hazard(32'h28, 32'h24);
      hazard(32'h28, 32'h24);
      hit(32'h28, alu_word(32'h28), 32'h2C, 1'b0);
      miss(32'h2C, 1'b1, 32'h28);
      hit(32'h2C, alu_word(32'h2C), 32'h30, 1'b0);
      check("stall_cnt_6", {48'h0, stall_cnt}, 64'd6);
      check("fetch_cnt_10", {48'h0, fetch_cnt}, 64'd10);
      check("sat_stall_cnt", {62'h0, stall_cnt2}, 64'd3);
      check("sat_fetch_cnt", {62'h0, fetch_cnt2}, 64'd3);
      check("sat_flush_cnt", {62'h0, flush_cnt2}, 64'd1);

      // Reset asserted in the middle of a MISS cycle.
      miss(32'h30, 1'b0, 32'h2C);
      u_ic.ic_ready = 1'b0;
      #2;
      check("premiss_req", {63'h0, u_ic.ic_req}, 64'd1);
      check("premiss_stall_cnt", {48'h0, stall_cnt}, 64'd7);
      rst = 1'b1;
      #1;
      check("arst_req", {63'h0, u_ic.ic_req}, 64'd0);
      check("arst_addr", {32'h0, u_ic.ic_addr}, 64'h0);
      check("arst_stall", {63'h0, stall}, 64'd1);
      check("arst_br", {63'h0, branch_if}, 64'd0);
      check("arst_ifid", {31'h0, if_id_valid, if_id_instr}, 64'h13);
      check("arst_if_id_pc", {32'h0, if_id_pc}, 64'h0);
      check("arst_cnts", {16'h0, fetch_cnt, flush_cnt, stall_cnt}, 64'h0);
      check("arst_cnts2", {58'h0, fetch_cnt2, flush_cnt2, stall_cnt2}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("sb_drained", {32'h0, exp_q.size()}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
